chunked_addsub: RTL

CHUNKED_ADDSUB -- requirements
Module: chunked_addsub

---
 rtl/addsub_pkg.sv | 19 +
 rtl/addsub_chunk.sv | 29 ++
 rtl/chunked_addsub.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared types and constants for the chunked add/subtract unit.
// The optional flag outputs are enabled by defining ADDSUB_FLAGS_EN.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Chunk index width, never narrower than one bit so a single-chunk build still has an index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// CHUNK-bit ripple-carry adder slice; also exposes the carry into its MSB for overflow detection.
module addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] w_c;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_c    = '0;
    s      = '0;
    w_c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]     = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = w_c[CHUNK];
  assign c_msb = w_c[CHUNK-1];

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle add/subtract that processes CHUNK bits per clock through one shared adder slice.
// Define ADDSUB_FLAGS_EN to add the signed-overflow (ovf) and zero-result (zero) outputs.
module chunked_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             addsub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDSUB_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = idx_width(NCHUNK);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("chunked_addsub: WIDTH must be a multiple of CHUNK");
  end

  state_e             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;

  logic [CHUNK-1:0]   w_a_chunk;
  logic [CHUNK-1:0]   w_b_chunk;
  logic [CHUNK-1:0]   w_s_chunk;
  logic               w_chunk_cout;
  logic [WIDTH-1:0]   w_sum_next;
  logic               w_last;
  logic               w_accept;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_idx == IDX_W'(NCHUNK - 1));

  // Select the active chunk and build the sum with that chunk replaced.
  always_comb begin
    w_a_chunk  = '0;
    w_b_chunk  = '0;
    w_sum_next = r_sum;
    for (int i = 0; i < NCHUNK; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_a_chunk                    = r_a[i*CHUNK +: CHUNK];
        w_b_chunk                    = r_b[i*CHUNK +: CHUNK];
        w_sum_next[i*CHUNK +: CHUNK] = w_s_chunk;
      end
    end
  end

`ifdef ADDSUB_FLAGS_EN
  logic w_c_msb;
  logic r_ovf;
  logic r_zero;
`endif

  addsub_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a     (w_a_chunk),
    .b     (w_b_chunk),
    .cin   (r_carry),
    .s     (w_s_chunk),
    .cout  (w_chunk_cout),
`ifdef ADDSUB_FLAGS_EN
    .c_msb (w_c_msb)
`else
    .c_msb ()
`endif
  );

  // NOTE: operand registers are pure datapath, loaded on acceptance and never read before then,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= a;
      r_b <= b ^ {WIDTH{addsub}};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
`ifdef ADDSUB_FLAGS_EN
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_carry <= addsub;
            r_idx   <= '0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_sum   <= w_sum_next;
          r_carry <= w_chunk_cout;
          if (w_last) begin
            r_cout  <= w_chunk_cout;
            r_idx   <= '0;
            r_state <= DONE;
`ifdef ADDSUB_FLAGS_EN
            r_ovf   <= w_c_msb ^ w_chunk_cout;
            r_zero  <= (w_sum_next == '0);
`endif
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
`ifdef ADDSUB_FLAGS_EN
  assign ovf       = r_ovf;
  assign zero      = r_zero;
`endif

endmodule
